// File: rtl/dyn_array_pkg.sv
// -----------------------------------------------------------------------------
// dyn_array_pkg
// Shared types and default sizing for the dynamic-array controller.
//   cmd_op_t : command opcodes carried on cmd_op
//   state_t  : controller states (FILL is only entered when the
//              DYN_ARRAY_SCRUB_EN macro is defined)
// -----------------------------------------------------------------------------
package dyn_array_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        OP_NEW    = 2'b00,
        OP_RESIZE = 2'b01,
        OP_DELETE = 2'b10,
        OP_NOP    = 2'b11
    } cmd_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/dyn_array_ram.sv
// -----------------------------------------------------------------------------
// dyn_array_ram
// Single-port synchronous RAM, WIDTH x DEPTH, one-cycle registered read.
// Contents and read register are not reset.
// Ports:
//   clk   : clock
//   we    : write enable (writes wdata to addr on the rising edge)
//   re    : read enable (captures mem[addr] into rdata on the rising edge)
//   addr  : element address
//   wdata : write data
//   rdata : registered read data, holds until the next read
// -----------------------------------------------------------------------------
module dyn_array_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dyn_array_ctrl.sv
// -----------------------------------------------------------------------------
// dyn_array_ctrl
// Manages a fixed on-chip RAM as one runtime-sizable array (new[n],
// new[n](old), delete()) and provides a bounds-checked element access port.
// Optional feature macro: DYN_ARRAY_SCRUB_EN -- when defined, newly exposed
// entries are zero-filled one per cycle in the FILL state before the new size
// becomes visible; when undefined, the size changes immediately and new
// entries hold stale RAM contents.
// Ports:
//   clk, nreset          : clock, asynchronous active-low reset
//   cmd_valid/ready      : command handshake (ready only in IDLE)
//   cmd_op, cmd_size     : opcode (NEW/RESIZE/DELETE/NOP) and element count
//   cmd_err              : one-cycle pulse, cmd_size > DEPTH rejected
//   size                 : current element count
//   acc_valid/ready      : access handshake (commands take priority)
//   acc_we, acc_idx,
//   acc_wdata            : access direction, index and write data
//   rd_valid, rd_data    : read result pulse and held read data
//   acc_err              : one-cycle pulse, index out of range
// -----------------------------------------------------------------------------
module dyn_array_ctrl
    import dyn_array_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW:0]      cmd_size,
    output logic             cmd_err,
    output logic [AW:0]      size,
    input  logic             acc_valid,
    output logic             acc_ready,
    input  logic             acc_we,
    input  logic [AW-1:0]    acc_idx,
    input  logic [WIDTH-1:0] acc_wdata,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             acc_err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [AW:0]      size_q, size_d;
    logic [AW:0]      fill_ptr_q, fill_ptr_d;
    logic [AW:0]      fill_end_q, fill_end_d;
    logic             cmd_err_q, cmd_err_d;
    logic             acc_err_q, acc_err_d;
    logic             rd_valid_q, rd_valid_d;
    // Forces rd_data to zero after reset and after an out-of-range read,
    // so the RAM read register itself never needs a reset.
    logic             rd_zero_q, rd_zero_d;

    logic             cmd_fire_s;
    logic             acc_fire_s;
    logic             in_range_s;
    logic [AW:0]      range_lo_s;
    logic             ram_we_s;
    logic             ram_re_s;
    logic [AW-1:0]    ram_addr_s;
    logic [WIDTH-1:0] ram_wdata_s;
    logic [WIDTH-1:0] ram_rdata_s;

    assign cmd_ready  = (state_q == IDLE);
    assign acc_ready  = (state_q == IDLE) && !cmd_valid;
    assign cmd_fire_s = cmd_valid && cmd_ready;
    assign acc_fire_s = acc_valid && acc_ready;
    assign in_range_s = ({1'b0, acc_idx} < size_q);
    // First newly exposed index: 0 for NEW, current size for RESIZE.
    assign range_lo_s = (cmd_op_t'(cmd_op) == OP_RESIZE) ? size_q : {(AW+1){1'b0}};

    // Next-state, command decode, access decode and RAM port mux.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        fill_ptr_d  = fill_ptr_q;
        fill_end_d  = fill_end_q;
        cmd_err_d   = 1'b0;
        acc_err_d   = 1'b0;
        rd_valid_d  = 1'b0;
        rd_zero_d   = rd_zero_q;
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_addr_s  = acc_idx;
        ram_wdata_s = acc_wdata;

        case (state_q)
            IDLE: begin
                if (cmd_fire_s) begin
                    case (cmd_op_t'(cmd_op))
                        OP_NEW, OP_RESIZE: begin
                            if (cmd_size > DEPTH_C) begin
                                cmd_err_d = 1'b1;
                            end else if (cmd_size <= range_lo_s) begin
                                // Empty target range (shrink, equal, or NEW 0).
                                size_d = cmd_size;
                            end else begin
`ifdef DYN_ARRAY_SCRUB_EN
                                state_d    = FILL;
                                fill_ptr_d = range_lo_s;
                                fill_end_d = cmd_size;
                                // NEW discards the old array, so it reads as empty while filling.
                                if (cmd_op_t'(cmd_op) == OP_NEW) begin
                                    size_d = {(AW+1){1'b0}};
                                end else begin
                                    size_d = size_q;
                                end
`else
                                size_d = cmd_size;
`endif
                            end
                        end
                        OP_DELETE: begin
                            size_d = {(AW+1){1'b0}};
                        end
                        OP_NOP: begin
                            size_d = size_q;
                        end
                        default: begin
                            size_d = size_q;
                        end
                    endcase
                end else if (acc_fire_s) begin
                    if (in_range_s) begin
                        if (acc_we) begin
                            ram_we_s = 1'b1;
                        end else begin
                            ram_re_s   = 1'b1;
                            rd_valid_d = 1'b1;
                            rd_zero_d  = 1'b0;
                        end
                    end else begin
                        acc_err_d = 1'b1;
                        if (acc_we) begin
                            rd_valid_d = 1'b0;
                        end else begin
                            rd_valid_d = 1'b1;
                            rd_zero_d  = 1'b1;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                ram_we_s    = 1'b1;
                ram_addr_s  = fill_ptr_q[AW-1:0];
                ram_wdata_s = {WIDTH{1'b0}};
                fill_ptr_d  = fill_ptr_q + (AW+1)'(1);
                // The last zero write and the size update share one edge.
                if (fill_ptr_d == fill_end_q) begin
                    size_d  = fill_end_q;
                    state_d = IDLE;
                end else begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            size_q     <= {(AW+1){1'b0}};
            fill_ptr_q <= {(AW+1){1'b0}};
            fill_end_q <= {(AW+1){1'b0}};
            cmd_err_q  <= 1'b0;
            acc_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            fill_ptr_q <= fill_ptr_d;
            fill_end_q <= fill_end_d;
            cmd_err_q  <= cmd_err_d;
            acc_err_q  <= acc_err_d;
            rd_valid_q <= rd_valid_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    dyn_array_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign size     = size_q;
    assign cmd_err  = cmd_err_q;
    assign acc_err  = acc_err_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_zero_q ? {WIDTH{1'b0}} : ram_rdata_s;

endmodule

// File: tb/tb_dyn_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dyn_array_ctrl
// Self-checking bench for dyn_array_ctrl. The reference model is a native
// SystemVerilog dynamic array (new[n], new[n](old)) plus a per-entry "known"
// flag; entries exposed without zero-fill (DYN_ARRAY_SCRUB_EN undefined)
// are unknown until written and are not compared.
// -----------------------------------------------------------------------------
module tb_dyn_array_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             nreset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [AW:0]      cmd_size;
    logic             cmd_err;
    logic [AW:0]      size;
    logic             acc_valid;
    logic             acc_ready;
    logic             acc_we;
    logic [AW-1:0]    acc_idx;
    logic [WIDTH-1:0] acc_wdata;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             acc_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] md [];
    bit               mk [];

`ifdef DYN_ARRAY_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    always #5 clk = ~clk;

    dyn_array_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_size  (cmd_size),
        .cmd_err   (cmd_err),
        .size      (size),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_we    (acc_we),
        .acc_idx   (acc_idx),
        .acc_wdata (acc_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .acc_err   (acc_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it to completion, updating the model.
    task automatic do_cmd(input int op, input int n);
        int old_sz   = md.size();
        bit exp_err  = (op == 0 || op == 1) && (n > DEPTH);
        int exp_fill = 0;
        int exp_sz   = old_sz;
        int cycles   = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_size  = 5'(n);
        #1;
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        check_eq("cmd_err", 32'(cmd_err), 32'(exp_err));
        if (!exp_err) begin
            if (op == 0) begin
                exp_fill = n;
                exp_sz   = n;
                md = new[n];
                mk = new[n];
                foreach (mk[i]) mk[i] = SCRUB;
            end else if (op == 1) begin
                exp_fill = (n > old_sz) ? n - old_sz : 0;
                exp_sz   = n;
                md = new[n](md);
                mk = new[n](mk);
                for (int i = old_sz; i < n; i++) mk[i] = SCRUB;
            end else if (op == 2) begin
                exp_sz = 0;
                md = new[0];
                mk = new[0];
            end
        end
        if (SCRUB && exp_fill > 0) begin
            check_eq("size_during_fill", 32'(size), (op == 0) ? 32'd0 : 32'(old_sz));
            while (!cmd_ready && cycles < 200) begin
                tick();
                cycles++;
            end
            check_eq("fill_cycles", 32'(cycles), 32'(exp_fill));
        end else begin
            check_eq("ready_no_fill", 32'(cmd_ready), 32'd1);
        end
        check_eq("size", 32'(size), 32'(exp_sz));
    endtask

    // Issue one access and check its result against the model.
    task automatic do_acc(input bit we, input int idx, input int wd);
        bit inr = (idx < md.size());
        acc_valid = 1'b1;
        acc_we    = we;
        acc_idx   = 4'(idx);
        acc_wdata = 8'(wd);
        #1;
        check_eq("acc_ready", 32'(acc_ready), 32'd1);
        tick();
        acc_valid = 1'b0;
        check_eq("acc_err", 32'(acc_err), 32'(!inr));
        check_eq("rd_valid", 32'(rd_valid), 32'(!we));
        if (!we) begin
            if (!inr) begin
                check_eq("rd_oob_zero", 32'(rd_data), 32'd0);
            end else if (mk[idx]) begin
                check_eq("rd_data", 32'(rd_data), 32'(md[idx]));
            end
        end else if (inr) begin
            md[idx] = 8'(wd);
            mk[idx] = 1'b1;
        end
    endtask

    initial begin
        int c;
        nreset    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_size  = 5'd0;
        acc_valid = 1'b0;
        acc_we    = 1'b0;
        acc_idx   = 4'd0;
        acc_wdata = 8'd0;
        md = new[0];
        mk = new[0];
        #12;
        check_eq("rst_size", 32'(size), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_cmd_err", 32'(cmd_err), 32'd0);
        check_eq("rst_acc_err", 32'(acc_err), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        nreset = 1'b1;
        tick();

        // Allocate and grow.
        do_cmd(0, 4);
        for (int i = 0; i < 4; i++) do_acc(1'b1, i, i);
        do_cmd(1, 8);
        for (int i = 0; i < 8; i++) do_acc(1'b0, i, 0);

        // Shrink, out-of-range read, delete.
        do_cmd(1, 2);
        do_acc(1'b0, 3, 0);
        do_acc(1'b1, 5, 8'hAA);
        do_cmd(2, 9);

        // Overflow and full capacity.
        do_cmd(0, 17);
        do_cmd(1, 31);
        do_cmd(0, 16);
        do_acc(1'b1, 15, 8'h5A);
        do_acc(1'b0, 15, 0);

        // Command wins over a same-cycle access.
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_size  = 5'd0;
        acc_valid = 1'b1;
        acc_we    = 1'b0;
        acc_idx   = 4'd15;
        #1;
        check_eq("prio_acc_ready", 32'(acc_ready), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check_eq("prio_no_read", 32'(rd_valid), 32'd0);
        check_eq("prio_size", 32'(size), 32'(md.size()));
        c = 0;
        while (!acc_ready && c < 50) begin
            tick();
            c++;
        end
        check_eq("prio_acc_later", 32'(acc_ready), 32'd1);
        tick();
        acc_valid = 1'b0;
        check_eq("prio_rd_valid", 32'(rd_valid), 32'd1);
        check_eq("prio_rd_data", 32'(rd_data), 32'h5A);

        // Reset in the middle of a fill.
        do_cmd(2, 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_size  = 5'd8;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        tick();
        tick();
        #2;
        nreset = 1'b0;
        #1;
        check_eq("midfill_size", 32'(size), 32'd0);
        check_eq("midfill_ready", 32'(cmd_ready), 32'd1);
        check_eq("midfill_rd_valid", 32'(rd_valid), 32'd0);
        md = new[0];
        mk = new[0];
        @(negedge clk);
        nreset = 1'b1;
        tick();
        do_cmd(0, 2);
        do_acc(1'b0, 0, 0);
        do_acc(1'b0, 1, 0);
        do_acc(1'b0, 2, 0);

        // Randomized mix of commands and accesses.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 17)));
            end else begin
                do_acc(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 255)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
